// File: rtl/dmi_bus_arbiter.sv
// Two-master (JTAG DTM / APB) arbiter in front of the debug-module register file.
// One transaction in flight: accept -> drive DM request -> wait for data or timeout -> return response.
module dmi_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_jtag_req_valid,
  output logic        o_jtag_req_ready,
  input  logic        i_jtag_write,
  input  logic [6:0]  i_jtag_addr,
  input  logic [31:0] i_jtag_wdata,
  output logic        o_jtag_resp_valid,
  input  logic        i_jtag_resp_ready,
  output logic [31:0] o_jtag_resp_data,
  output logic        o_jtag_resp_err,
  input  logic        i_apb_req_valid,
  output logic        o_apb_req_ready,
  input  logic        i_apb_write,
  input  logic [6:0]  i_apb_addr,
  input  logic [31:0] i_apb_wdata,
  output logic        o_apb_resp_valid,
  output logic [31:0] o_apb_resp_data,
  output logic        o_apb_resp_err,
  output logic        o_dm_req_valid,
  input  logic        i_dm_req_ready,
  output logic        o_dm_write,
  output logic [6:0]  o_dm_addr,
  output logic [31:0] o_dm_wdata,
  output logic        o_dm_bus_jtag,
  input  logic        i_dm_resp_valid,
  input  logic [31:0] i_dm_resp_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  r_state;
  logic        r_last_jtag;
  logic        r_owner;
  logic        r_write;
  logic [6:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_resp_data;
  logic        r_resp_err;
  logic [15:0] r_cnt;

  logic w_idle;
  logic w_jtag_win;
  logic w_apb_win;
  logic w_timeout;

  // On a tie the source that was not served last wins.
  assign w_idle     = (r_state == S_IDLE);
  assign w_jtag_win = w_idle & i_jtag_req_valid & (~i_apb_req_valid | ~r_last_jtag);
  assign w_apb_win  = w_idle & i_apb_req_valid & (~i_jtag_req_valid | r_last_jtag);
  assign w_timeout  = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  assign o_jtag_req_ready  = w_jtag_win;
  assign o_apb_req_ready   = w_apb_win;
  assign o_dm_req_valid    = (r_state == S_REQ);
  assign o_dm_write        = r_write;
  assign o_dm_addr         = r_addr;
  assign o_dm_wdata        = r_wdata;
  assign o_dm_bus_jtag     = r_owner;
  assign o_jtag_resp_valid = (r_state == S_RESP) & r_owner;
  assign o_apb_resp_valid  = (r_state == S_RESP) & ~r_owner;
  assign o_jtag_resp_data  = r_resp_data;
  assign o_jtag_resp_err   = r_resp_err;
  assign o_apb_resp_data   = r_resp_data;
  assign o_apb_resp_err    = r_resp_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last_jtag <= 1'b0;
      r_owner     <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= 7'd0;
      r_wdata     <= 32'd0;
      r_resp_data <= 32'd0;
      r_resp_err  <= 1'b0;
      r_cnt       <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_jtag_win | w_apb_win) begin
            r_owner     <= w_jtag_win;
            r_last_jtag <= w_jtag_win;
            r_write     <= w_jtag_win ? i_jtag_write : i_apb_write;
            r_addr      <= w_jtag_win ? i_jtag_addr  : i_apb_addr;
            r_wdata     <= w_jtag_win ? i_jtag_wdata : i_apb_wdata;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_dm_req_ready) begin
            r_cnt   <= 16'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A real response beats a timeout landing in the same cycle.
          if (i_dm_resp_valid) begin
            r_resp_data <= i_dm_resp_data;
            r_resp_err  <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_resp_data <= 32'd0;
            r_resp_err  <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (~r_owner | i_jtag_resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmi_bus_arbiter.md
DMI_BUS_ARBITER -- requirements
Module: dmi_bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 255, max cycles in WAIT_RESP before a forced error response (range 2..65535).
REQ-002 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 i_rst  in  1  reset; synchronous, active-high.
REQ-004 i_jtag_req_valid / o_jtag_req_ready  in/out  1/1  JTAG DTM request handshake.
REQ-005 i_jtag_write  in  1  1=write, 0=read; i_jtag_addr  in  7  DM register index; i_jtag_wdata  in  32  write data.
REQ-006 o_jtag_resp_valid / i_jtag_resp_ready  out/in  1/1  JTAG response handshake; o_jtag_resp_data  out  32; o_jtag_resp_err  out  1.
REQ-007 i_apb_req_valid / o_apb_req_ready  in/out  1/1  APB-side request handshake; i_apb_write  in  1; i_apb_addr  in  7; i_apb_wdata  in  32.
REQ-008 o_apb_resp_valid  out  1  one-cycle response pulse (no back-pressure); o_apb_resp_data  out  32; o_apb_resp_err  out  1.
REQ-009 o_dm_req_valid / i_dm_req_ready  out/in  1/1  request to debug-module register file; o_dm_write  out  1; o_dm_addr  out  7; o_dm_wdata  out  32; o_dm_bus_jtag  out  1  1 = current owner is JTAG.
REQ-010 i_dm_resp_valid  in  1; i_dm_resp_data  in  32  debug-module read data/ack.

Function
REQ-011 States SHALL be IDLE, REQ, WAIT_RESP, RESP; exactly one transaction in flight.
REQ-012 In IDLE, o_jtag_req_ready/o_apb_req_ready SHALL be asserted combinationally only to the arbitration winner; both 0 in other states.
REQ-013 Arbitration: single requester wins; both valid -> the source not served last wins (round-robin on last_jtag flag).
REQ-014 On accepted handshake the block SHALL register write/addr/wdata and owner, set last_jtag=owner, go to REQ next cycle.
REQ-015 In REQ, o_dm_req_valid=1 with registered fields stable until i_dm_req_ready=1, then go to WAIT_RESP and clear timeout counter.
REQ-016 In WAIT_RESP, i_dm_resp_valid=1 SHALL capture i_dm_resp_data, err=0, go to RESP.
REQ-017 Timeout counter increments each WAIT_RESP cycle without response; on reaching TIMEOUT_CYCLES-1 capture data=32'h0, err=1, go to RESP.
REQ-018 Response and timeout in the same cycle: response SHALL win (err=0).
REQ-019 i_dm_resp_valid outside WAIT_RESP SHALL be ignored.
REQ-020 In RESP, owner JTAG: o_jtag_resp_valid=1 held with data/err stable until i_jtag_resp_ready=1, then IDLE.
REQ-021 In RESP, owner APB: o_apb_resp_valid=1 for exactly one cycle, then IDLE.
REQ-022 Minimum latency accept->resp_valid SHALL be 3 cycles (dm ready and response each in first possible cycle); new request accepted earliest the cycle after RESP completes.
REQ-023 o_dm_bus_jtag SHALL equal registered owner in all states; resp_data/err outputs hold last captured value when resp_valid=0.
REQ-024 Requests withdrawn before handshake SHALL not change state or last_jtag.

Reset
REQ-025 i_rst=1 SHALL force IDLE, counter=0, last_jtag=0 (JTAG wins first tie), owner=0, captured data=0, err=0, all valid/ready outputs 0 except combinational IDLE readies.
REQ-026 Reset mid-transaction SHALL abandon it without emitting any response; next cycle after release behaves as fresh IDLE.

Verification
REQ-027 JTAG read addr 7'h11, DM ready immediate, resp 32'h00000382 next cycle -> o_jtag_resp_valid at accept+3, data 32'h00000382, err=0, o_dm_bus_jtag=1.
REQ-028 Both request same cycle after reset -> JTAG granted first; APB granted next; a third simultaneous pair -> JTAG again.
REQ-029 APB write addr 7'h04 data 32'hCAFEF00D, DM never responds, TIMEOUT_CYCLES=4 -> o_apb_resp_valid single pulse, data 0, err=1.
REQ-030 JTAG response with i_jtag_resp_ready low 5 cycles -> resp held stable 5 cycles, APB request stalled (ready=0) until release.
REQ-031 i_dm_resp_valid on the exact timeout cycle -> err=0, DM data returned.
REQ-032 i_rst pulsed during WAIT_RESP -> no resp_valid on either side; subsequent JTAG read completes normally.
